// File: rtl/power_pack_mgr.sv
// Power-up pack manager: spawns packs into free slots, detects ball overlap,
// ages packs per frame, runs the eaten-pack effect timer and draws the packs.
module power_pack_mgr #(
  parameter int          N_SLOTS     = 2,
  parameter int          WIDTH       = 20,
  parameter int          HEIGHT      = 20,
  parameter int          BALL_SIZE   = 16,
  parameter int          LIFETIME    = 600,
  parameter int          EFFECT_TIME = 300,
  parameter logic [7:0]  COLOR       = 8'b000_000_11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn,
  input  logic [10:0] randx,
  input  logic [9:0]  randy,
  input  logic [1:0]  randmode,
  input  logic [10:0] ball_x,
  input  logic [9:0]  ball_y,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  pixel,
  output logic        randop,
  output logic        spawn_drop,
  output logic        eat_pulse,
  output logic [1:0]  effect_mode,
  output logic        effect_active
);

  localparam int LW = $clog2(LIFETIME + 1);
  localparam int EW = $clog2(EFFECT_TIME + 1);

  // Half-open intervals [a0, a0+alen) and [b0, b0+blen) intersect; 12 bits so the ends never wrap.
  function automatic logic spans(input logic [11:0] a0, input logic [11:0] alen,
                                 input logic [11:0] b0, input logic [11:0] blen);
    return (a0 < b0 + blen) && (b0 < a0 + alen);
  endfunction

  logic [N_SLOTS-1:0] active_q, active_d;
  logic [10:0]        x_q    [N_SLOTS];
  logic [10:0]        x_d    [N_SLOTS];
  logic [9:0]         y_q    [N_SLOTS];
  logic [9:0]         y_d    [N_SLOTS];
  logic [1:0]         mode_q [N_SLOTS];
  logic [1:0]         mode_d [N_SLOTS];
  logic [LW-1:0]      cnt_q  [N_SLOTS];
  logic [LW-1:0]      cnt_d  [N_SLOTS];
  logic [EW-1:0]      eff_q, eff_d;
  logic [1:0]         effect_mode_q, effect_mode_d;
  logic               eat_pulse_q, eat_pulse_d;
  logic               randop_q, randop_d;
  logic               spawn_drop_q, spawn_drop_d;
  logic               effect_active_q, effect_active_d;
  logic [7:0]         pixel_q, pixel_d;

  logic [N_SLOTS-1:0] hit_s, on_s, sel_s;
  logic               sel_found_s, eat_found_s;
  logic [1:0]         eat_mode_s;

  // Per-slot ball overlap and raster hit, both from start-of-cycle slot state.
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      hit_s[i] = active_q[i]
               && spans({1'b0, ball_x}, 12'(BALL_SIZE), {1'b0, x_q[i]}, 12'(WIDTH))
               && spans({2'b00, ball_y}, 12'(BALL_SIZE), {2'b00, y_q[i]}, 12'(HEIGHT));
      on_s[i]  = active_q[i]
               && spans({1'b0, hcount}, 12'd1, {1'b0, x_q[i]}, 12'(WIDTH))
               && spans({2'b00, vcount}, 12'd1, {2'b00, y_q[i]}, 12'(HEIGHT));
    end
  end

  // Lowest-index idle slot for spawning and lowest-index eaten slot for the effect mode.
  always_comb begin
    sel_s       = '0;
    sel_found_s = 1'b0;
    eat_found_s = 1'b0;
    eat_mode_s  = effect_mode_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!active_q[i] && !sel_found_s) begin
        sel_s[i]    = 1'b1;
        sel_found_s = 1'b1;
      end else begin
        sel_s[i]    = 1'b0;
      end
      if (hit_s[i] && !eat_found_s) begin
        eat_mode_s  = mode_q[i];
        eat_found_s = 1'b1;
      end else begin
        eat_found_s = eat_found_s;
      end
    end
  end

  // Slot updates: eating beats expiry; spawning only touches slots idle at the start of the cycle.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (hit_s[i]) begin
        active_d[i] = 1'b0;
      end else if (active_q[i] && frame_tick) begin
        cnt_d[i]    = cnt_q[i] - LW'(1);
        active_d[i] = (cnt_q[i] != LW'(1));
      end else if (spawn && sel_s[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = randx;
        y_d[i]      = randy;
        mode_d[i]   = randmode;
        cnt_d[i]    = LW'(LIFETIME);
      end else begin
        active_d[i] = active_q[i];
      end
    end
  end

  // Effect timer, pulses and pixel colour.
  always_comb begin
    if (|hit_s) begin
      eff_d         = EW'(EFFECT_TIME);
      effect_mode_d = eat_mode_s;
    end else if (frame_tick && (eff_q != '0)) begin
      eff_d         = eff_q - EW'(1);
      effect_mode_d = effect_mode_q;
    end else begin
      eff_d         = eff_q;
      effect_mode_d = effect_mode_q;
    end
    effect_active_d = (eff_d != '0);
    eat_pulse_d     = |hit_s;
    randop_d        = spawn && sel_found_s;
    spawn_drop_d    = spawn && !sel_found_s;
    pixel_d         = (|on_s) ? COLOR : 8'h00;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q        <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        x_q[i]    <= 11'd0;
        y_q[i]    <= 10'd0;
        mode_q[i] <= 2'd0;
        cnt_q[i]  <= '0;
      end
      eff_q           <= '0;
      effect_mode_q   <= 2'd0;
      eat_pulse_q     <= 1'b0;
      randop_q        <= 1'b0;
      spawn_drop_q    <= 1'b0;
      effect_active_q <= 1'b0;
      pixel_q         <= 8'h00;
    end else begin
      active_q        <= active_d;
      x_q             <= x_d;
      y_q             <= y_d;
      mode_q          <= mode_d;
      cnt_q           <= cnt_d;
      eff_q           <= eff_d;
      effect_mode_q   <= effect_mode_d;
      eat_pulse_q     <= eat_pulse_d;
      randop_q        <= randop_d;
      spawn_drop_q    <= spawn_drop_d;
      effect_active_q <= effect_active_d;
      pixel_q         <= pixel_d;
    end
  end

  assign pixel         = pixel_q;
  assign randop        = randop_q;
  assign spawn_drop    = spawn_drop_q;
  assign eat_pulse     = eat_pulse_q;
  assign effect_mode   = effect_mode_q;
  assign effect_active = effect_active_q;

endmodule

// File: tb/tb_power_pack_mgr.sv
// Self-checking bench for power_pack_mgr: directed scenarios plus a randomized
// run, all checked against a slot-list reference model.
module tb_power_pack_mgr;
  localparam int N = 2, W = 20, H = 20, B = 16, LIFE = 600, EFF = 300;
  localparam logic [7:0] COL = 8'b000_000_11;

  logic clk = 1'b0;
  logic reset, frame_tick, spawn;
  logic [10:0] randx, ball_x, hcount;
  logic [9:0]  randy, ball_y, vcount;
  logic [1:0]  randmode;
  logic [7:0]  pixel;
  logic randop, spawn_drop, eat_pulse, effect_active;
  logic [1:0]  effect_mode;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  power_pack_mgr #(.N_SLOTS(N), .WIDTH(W), .HEIGHT(H), .BALL_SIZE(B),
                   .LIFETIME(LIFE), .EFFECT_TIME(EFF), .COLOR(COL)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .spawn(spawn),
    .randx(randx), .randy(randy), .randmode(randmode),
    .ball_x(ball_x), .ball_y(ball_y), .hcount(hcount), .vcount(vcount),
    .pixel(pixel), .randop(randop), .spawn_drop(spawn_drop), .eat_pulse(eat_pulse),
    .effect_mode(effect_mode), .effect_active(effect_active));

  // Reference model: a list of packs with remaining life, plus an effect countdown.
  typedef struct { bit act; int x; int y; int mode; int life; } slot_t;
  slot_t m [N];
  int m_eff, m_emode;
  logic [7:0] e_pixel;
  logic e_randop, e_drop, e_eat, e_act;
  logic [1:0] e_mode;

  task automatic step();
    int first_idle;
    bit any_eat;
    bit hit [N];
    if (reset) begin
      for (int i = 0; i < N; i++) m[i] = '{1'b0, 0, 0, 0, 0};
      m_eff = 0; m_emode = 0;
      e_pixel = 8'h00; e_randop = 1'b0; e_drop = 1'b0; e_eat = 1'b0;
    end else begin
      e_pixel = 8'h00;
      any_eat = 1'b0;
      first_idle = -1;
      for (int i = 0; i < N; i++) begin
        if (m[i].act && int'(hcount) >= m[i].x && int'(hcount) < m[i].x + W &&
            int'(vcount) >= m[i].y && int'(vcount) < m[i].y + H) e_pixel = COL;
        hit[i] = m[i].act && int'(ball_x) < m[i].x + W && m[i].x < int'(ball_x) + B &&
                 int'(ball_y) < m[i].y + H && m[i].y < int'(ball_y) + B;
        if (hit[i] && !any_eat) begin any_eat = 1'b1; m_emode = m[i].mode; end
        if (!m[i].act && first_idle < 0) first_idle = i;
      end
      if (any_eat) m_eff = EFF;
      else if (frame_tick && m_eff > 0) m_eff--;
      for (int i = 0; i < N; i++) begin
        if (hit[i]) m[i].act = 1'b0;
        else if (m[i].act && frame_tick) begin
          m[i].life--;
          if (m[i].life == 0) m[i].act = 1'b0;
        end
      end
      e_randop = spawn && first_idle >= 0;
      e_drop   = spawn && first_idle < 0;
      if (e_randop) m[first_idle] = '{1'b1, int'(randx), int'(randy), int'(randmode), LIFE};
      e_eat = any_eat;
    end
    e_mode = 2'(m_emode);
    e_act  = m_eff > 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; frame_tick = 1'b0; spawn = 1'b0;
    randx = 11'd0; randy = 10'd0; randmode = 2'd0;
    ball_x = 11'd2030; ball_y = 10'd1000; hcount = 11'd0; vcount = 10'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic do_spawn(input int x, input int y, input int md);
    spawn = 1'b1; randx = 11'(x); randy = 10'(y); randmode = 2'(md);
    step();
    spawn = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; spawn = 1'b1; frame_tick = 1'b1; randx = 11'd10; randy = 10'd10;
    ball_x = 11'd10; ball_y = 10'd10; hcount = 11'd12; vcount = 10'd12;
    step(); step();
    checks++; if (pixel !== 8'h00) begin failures++; $display("FAIL reset_pixel got=%0h exp=0", pixel); end
    checks++; if (randop !== 1'b0) begin failures++; $display("FAIL reset_randop got=%b exp=0", randop); end
    checks++; if (spawn_drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", spawn_drop); end
    checks++; if (eat_pulse !== 1'b0) begin failures++; $display("FAIL reset_eat got=%b exp=0", eat_pulse); end
    checks++; if (effect_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", effect_mode); end
    checks++; if (effect_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", effect_active); end
    reset = 1'b0; spawn = 1'b0; frame_tick = 1'b0;
    step(); step();
    checks++; if (pixel !== 8'h00) begin failures++; $display("FAIL reset_noslot pixel got=%0h exp=0", pixel); end
  endtask

  task automatic test_spawn_sweep();
    int vs [5] = '{499, 500, 510, 519, 520};
    logic [7:0] want;
    do_reset();
    do_spawn(700, 500, 1);
    checks++; if (randop !== 1'b1) begin failures++; $display("FAIL sweep_randop got=%b exp=1", randop); end
    step();
    checks++; if (randop !== 1'b0) begin failures++; $display("FAIL sweep_randop_clear got=%b exp=0", randop); end
    foreach (vs[k]) begin
      for (int h = 697; h <= 722; h++) begin
        hcount = 11'(h); vcount = 10'(vs[k]);
        step();
        want = (h >= 700 && h <= 719 && vs[k] >= 500 && vs[k] <= 519) ? COL : 8'h00;
        checks++;
        if (pixel !== want) begin failures++; $display("FAIL sweep_pixel h=%0d v=%0d got=%0h exp=%0h", h, vs[k], pixel, want); end
      end
    end
  endtask

  task automatic test_fill_drop();
    logic [1:0] want_op, want_dr;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      spawn = (k < 3); randx = 11'(100 + 50 * k); randy = 10'd100; randmode = 2'(k);
      step();
      want_op = (k < 2) ? 2'd1 : 2'd0;
      want_dr = (k == 2) ? 2'd1 : 2'd0;
      checks++; if (randop !== want_op[0]) begin failures++; $display("FAIL fill_randop k=%0d got=%b exp=%b", k, randop, want_op[0]); end
      checks++; if (spawn_drop !== want_dr[0]) begin failures++; $display("FAIL fill_drop k=%0d got=%b exp=%b", k, spawn_drop, want_dr[0]); end
    end
    spawn = 1'b0;
  endtask

  task automatic test_eat();
    int ticks;
    do_reset();
    do_spawn(700, 500, 3);
    step();
    ball_x = 11'd690; ball_y = 10'd495;
    step();
    ball_x = 11'd2030; ball_y = 10'd1000;
    checks++; if (eat_pulse !== 1'b1) begin failures++; $display("FAIL eat_pulse got=%b exp=1", eat_pulse); end
    checks++; if (effect_mode !== 2'd3) begin failures++; $display("FAIL eat_mode got=%0d exp=3", effect_mode); end
    checks++; if (effect_active !== 1'b1) begin failures++; $display("FAIL eat_active got=%b exp=1", effect_active); end
    step();
    checks++; if (eat_pulse !== 1'b0) begin failures++; $display("FAIL eat_pulse_once got=%b exp=0", eat_pulse); end
    ticks = 0;
    while (effect_active === 1'b1 && ticks < 400) begin
      frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
      ticks++;
      checks++; if (effect_active !== e_act) begin failures++; $display("FAIL eat_timer tick=%0d got=%b exp=%b", ticks, effect_active, e_act); end
    end
    checks++; if (ticks != EFF) begin failures++; $display("FAIL eat_duration got=%0d exp=%0d", ticks, EFF); end
    checks++; if (effect_mode !== 2'd3) begin failures++; $display("FAIL eat_mode_hold got=%0d exp=3", effect_mode); end
  endtask

  task automatic test_lifetime();
    do_reset();
    do_spawn(300, 300, 2);
    hcount = 11'd305; vcount = 10'd305;
    for (int t = 1; t <= LIFE; t++) begin
      frame_tick = 1'b1; step();
      checks++; if (eat_pulse !== 1'b0) begin failures++; $display("FAIL life_eat t=%0d got=%b exp=0", t, eat_pulse); end
      checks++; if (pixel !== e_pixel) begin failures++; $display("FAIL life_pixel t=%0d got=%0h exp=%0h", t, pixel, e_pixel); end
    end
    frame_tick = 1'b0;
    step();
    checks++; if (pixel !== 8'h00) begin failures++; $display("FAIL life_expired got=%0h exp=0", pixel); end
    do_spawn(300, 300, 0);
    checks++; if (randop !== 1'b1) begin failures++; $display("FAIL life_reuse got=%b exp=1", randop); end
    do_spawn(600, 300, 0);
    do_spawn(900, 300, 0);
    checks++; if (spawn_drop !== 1'b1) begin failures++; $display("FAIL life_full got=%b exp=1", spawn_drop); end
  endtask

  task automatic test_multi_eat();
    do_reset();
    do_spawn(500, 500, 3);
    ball_x = 11'd505; ball_y = 10'd505; step();
    ball_x = 11'd2030; ball_y = 10'd1000;
    do_spawn(100, 100, 0);
    do_spawn(110, 100, 1);
    ball_x = 11'd105; ball_y = 10'd100; step();
    ball_x = 11'd2030; ball_y = 10'd1000;
    checks++; if (eat_pulse !== 1'b1) begin failures++; $display("FAIL multi_pulse got=%b exp=1", eat_pulse); end
    checks++; if (effect_mode !== 2'd0) begin failures++; $display("FAIL multi_mode got=%0d exp=0", effect_mode); end
    hcount = 11'd125; vcount = 10'd105; step();
    checks++; if (eat_pulse !== 1'b0) begin failures++; $display("FAIL multi_single got=%b exp=0", eat_pulse); end
    checks++; if (pixel !== 8'h00) begin failures++; $display("FAIL multi_idle got=%0h exp=0", pixel); end
    do_spawn(200, 200, 0);
    do_spawn(300, 200, 0);
    checks++; if (randop !== 1'b1) begin failures++; $display("FAIL multi_both_free got=%b exp=1", randop); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_spawn(400, 400, 2);
    do_spawn(800, 600, 1);
    ball_x = 11'd400; ball_y = 10'd400; step();
    ball_x = 11'd2030; ball_y = 10'd1000;
    for (int t = 0; t < 150; t++) begin frame_tick = 1'b1; step(); end
    frame_tick = 1'b0;
    hcount = 11'd805; vcount = 10'd605; step();
    checks++; if (pixel !== COL || effect_active !== 1'b1) begin failures++; $display("FAIL mid_setup pixel=%0h act=%b exp=%0h/1", pixel, effect_active, COL); end
    reset = 1'b1; ball_x = 11'd800; ball_y = 10'd600; frame_tick = 1'b1; step();
    reset = 1'b0; frame_tick = 1'b0;
    checks++; if ({pixel, randop, spawn_drop, eat_pulse, effect_mode, effect_active} !== 14'd0) begin
      failures++; $display("FAIL mid_reset got pix=%0h op=%b dr=%b eat=%b mode=%0d act=%b exp=all0", pixel, randop, spawn_drop, eat_pulse, effect_mode, effect_active); end
    step();
    checks++; if (pixel !== 8'h00 || eat_pulse !== 1'b0) begin failures++; $display("FAIL mid_after pix=%0h eat=%b exp=0/0", pixel, eat_pulse); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      spawn      = ($urandom_range(0, 7) == 0);
      randx      = 11'($urandom_range(0, 200));
      randy      = 10'($urandom_range(0, 200));
      randmode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        ball_x = 11'($urandom_range(0, 240)); ball_y = 10'($urandom_range(0, 240));
      end else begin
        ball_x = 11'd2030; ball_y = 10'd1000;
      end
      hcount = 11'($urandom_range(0, 239));
      vcount = 10'($urandom_range(0, 239));
      step();
      checks++;
      if (pixel !== e_pixel || randop !== e_randop || spawn_drop !== e_drop ||
          eat_pulse !== e_eat || effect_mode !== e_mode || effect_active !== e_act) begin
        failures++;
        $display("FAIL random c=%0d got pix=%0h op=%b dr=%b eat=%b mode=%0d act=%b exp pix=%0h op=%b dr=%b eat=%b mode=%0d act=%b",
                 c, pixel, randop, spawn_drop, eat_pulse, effect_mode, effect_active,
                 e_pixel, e_randop, e_drop, e_eat, e_mode, e_act);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_spawn_sweep();
    test_fill_drop();
    test_eat();
    test_lifetime();
    test_multi_eat();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/power_pack_mgr.md
POWER_PACK_MGR -- requirements
Module: power_pack_mgr

Interface
REQ-001 SHALL provide parameters:
- N_SLOTS, 2, number of independent power-up slots (1..4)
- WIDTH, 20, pack width in pixels
- HEIGHT, 20, pack height in pixels
- BALL_SIZE, 16, ball square side in pixels
- LIFETIME, 600, frames a pack stays on screen if not eaten
- EFFECT_TIME, 300, frames an effect stays active after eating
- COLOR, 8'b000_000_11, pack pixel colour

REQ-002 SHALL provide ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- spawn  in  1  request to place a new pack
- randx  in  11  random x position
- randy  in  10  random y position
- randmode  in  2  random mode (00 SHRINK, 01 BOOST, 10 SPARE, 11 SHIELD)
- ball_x  in  11  ball left edge
- ball_y  in  10  ball top edge
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- pixel  out  8  pack colour or 0
- randop  out  1  one-cycle pulse requesting fresh random values
- spawn_drop  out  1  one-cycle pulse when a spawn is refused
- eat_pulse  out  1  one-cycle pulse when any pack is eaten
- effect_mode  out  2  mode of the most recent eaten pack
- effect_active  out  1  high while the effect timer is nonzero

REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 Each slot SHALL hold state (IDLE or ACTIVE), x[10:0], y[9:0], mode[1:0] and a lifetime frame counter.
REQ-005 On spawn, the block SHALL load randx/randy/randmode into the lowest-index IDLE slot, set it ACTIVE, load its counter with LIFETIME, and pulse randop the next cycle.
REQ-006 On spawn with no IDLE slot, the block SHALL leave all slots unchanged, pulse spawn_drop, and not pulse randop.
REQ-007 Slot selection SHALL use slot state at the start of the cycle; a slot freed in the same cycle is not reusable until the next cycle.
REQ-008 An ACTIVE slot is eaten when the ball box [ball_x, ball_x+BALL_SIZE) x [ball_y, ball_y+BALL_SIZE) overlaps the pack box [x, x+WIDTH) x [y, y+HEIGHT); all comparisons are 12-bit unsigned, with no wrap.
REQ-009 An eaten slot SHALL go IDLE the next cycle; eat_pulse SHALL be high for exactly that cycle.
REQ-010 If several slots are eaten in one cycle, all SHALL go IDLE; effect_mode SHALL take the lowest-index eaten slot's mode; eat_pulse SHALL pulse once.
REQ-011 Eating SHALL load the effect timer with EFFECT_TIME; eating during an active effect SHALL reload the timer and replace effect_mode.
REQ-012 On each frame_tick, every ACTIVE slot counter and a nonzero effect timer SHALL decrement by 1.
REQ-013 An ACTIVE slot whose counter reaches 0 SHALL go IDLE; reaching 0 does not pulse eat_pulse.
REQ-014 Eating SHALL take priority over expiry in the same cycle.
REQ-015 effect_active SHALL be high while the effect timer is nonzero; effect_mode SHALL hold its value after expiry.
REQ-016 pixel SHALL be registered with one-cycle latency: COLOR if (hcount, vcount) lies inside any ACTIVE slot's box, else 0.
REQ-017 Spawn and eat SHALL NOT be gated by frame_tick; both are evaluated every clk cycle.

Reset
REQ-018 While reset is high, the block SHALL hold:
- all slots IDLE, with x, y, mode and counters at 0
- effect timer 0
- pixel, randop, spawn_drop, eat_pulse, effect_active and effect_mode all 0
REQ-019 Reset SHALL override spawn, eat and frame_tick in the same cycle.
REQ-020 Reset mid-effect or mid-lifetime SHALL abort immediately; no eat_pulse is issued.

Verification
REQ-021 Spawn with randx=700, randy=500, randmode=01, then sweep hcount/vcount -> slot0 ACTIVE, randop pulse; pixel=COLOR only for h 700..719, v 500..519, one cycle late.
REQ-022 N_SLOTS=2; three spawns on consecutive cycles -> slots 0 and 1 filled; third spawn gives spawn_drop=1, randop=0.
REQ-023 Ball at (690,495) against a pack at (700,500), mode 11 -> eat_pulse one cycle, effect_mode=11, effect_active=1 for exactly 300 frame_ticks.
REQ-024 Spawn, then 600 frame_ticks with no overlap -> slot IDLE after the 600th tick, no eat_pulse; a new spawn reuses slot0.
REQ-025 Ball overlapping slot0 (mode 00) and slot1 (mode 01) in the same cycle -> both IDLE, single eat_pulse, effect_mode=00.
REQ-026 Reset asserted while the effect timer =150 and one slot is ACTIVE -> next cycle, all outputs 0 and all slots IDLE.
